// File: rtl/pipe_instr_pkg.sv
// pipe_instr_pkg: shared definitions for the MIPS-I instruction legality checker.
//   - opcode / SPECIAL funct / REGIMM rt encodings
//   - cause_e: result cause codes
//   - CLS_*: bit positions inside class_mask
//   - stage_t: one pipeline stage record (valid, legal, nop, cause, pc, instr)
package pipe_instr_pkg;

    // pc is carried at a fixed maximum width inside the record; the top level
    // zero-extends on entry and slices back to PC_WIDTH at the result stage.
    localparam int PC_MAX_WIDTH = 64;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02,
                           OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05,
                           OP_BLEZ    = 6'h06, OP_BGTZ   = 6'h07, OP_ADDIU = 6'h09,
                           OP_SLTI    = 6'h0A, OP_SLTIU  = 6'h0B, OP_ANDI  = 6'h0C,
                           OP_ORI     = 6'h0D, OP_XORI   = 6'h0E, OP_LUI   = 6'h0F,
                           OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LWL   = 6'h22,
                           OP_LW      = 6'h23, OP_LBU    = 6'h24, OP_LHU   = 6'h25,
                           OP_LWR     = 6'h26, OP_SB     = 6'h28, OP_SH    = 6'h29,
                           OP_SW      = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL   = 6'h02, F_SRA  = 6'h03, F_SLLV = 6'h04,
                           F_SRLV = 6'h06, F_SRAV  = 6'h07, F_JR   = 6'h08, F_JALR = 6'h09,
                           F_MFHI = 6'h10, F_MTHI  = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13,
                           F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV  = 6'h1A, F_DIVU = 6'h1B,
                           F_ADDU = 6'h21, F_SUBU  = 6'h23, F_AND  = 6'h24, F_OR   = 6'h25,
                           F_XOR  = 6'h26, F_NOR   = 6'h27, F_SLT  = 6'h2A, F_SLTU = 6'h2B;

    localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;

    localparam int CLS_MULDIV = 0, CLS_HILO = 1, CLS_LWLR = 2, CLS_LINK = 3;

    typedef enum logic [1:0] {
        CAUSE_OK       = 2'd0,
        CAUSE_UNKNOWN  = 2'd1,
        CAUSE_RSVD     = 2'd2,
        CAUSE_DISABLED = 2'd3
    } cause_e;

    typedef struct packed {
        logic                    valid;
        logic                    legal;
        logic                    nop;
        cause_e                  cause;
        logic [PC_MAX_WIDTH-1:0] pc;
        logic [31:0]             instr;
    } stage_t;

endpackage

// File: rtl/pipe_instr_classify.sv
// pipe_instr_classify: purely combinational legality decode of one MIPS-I word.
//   instr_i      : instruction word
//   class_mask_i : per-class enables (CLS_* bit positions)
//   legal_o      : legal and enabled
//   nop_o        : word is all-zero
//   cause_o      : unknown > reserved-field > class-disabled > ok
module pipe_instr_classify
    import pipe_instr_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [3:0]  class_mask_i,
    output logic        legal_o,
    output logic        nop_o,
    output cause_e      cause_o
);
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sa;
    logic       known, rsvd_bad, cls_off;

    assign op = instr_i[31:26];
    assign rs = instr_i[25:21];
    assign rt = instr_i[20:16];
    assign rd = instr_i[15:11];
    assign sa = instr_i[10:6];
    assign fn = instr_i[5:0];

    always_comb begin
        known    = 1'b1;
        rsvd_bad = 1'b0;
        cls_off  = 1'b0;
        case (op)
            OP_SPECIAL: case (fn)
                F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU,
                F_SLLV, F_SRLV, F_SRAV:           rsvd_bad = |sa;
                F_SLL, F_SRL, F_SRA:              rsvd_bad = |rs;
                F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                    rsvd_bad = |{rd, sa};
                    cls_off  = !class_mask_i[CLS_MULDIV];
                end
                F_MFHI, F_MFLO: begin
                    rsvd_bad = |{rs, rt, sa};
                    cls_off  = !class_mask_i[CLS_HILO];
                end
                F_MTHI, F_MTLO: begin
                    rsvd_bad = |{rt, rd, sa};
                    cls_off  = !class_mask_i[CLS_HILO];
                end
                F_JR:                             rsvd_bad = |instr_i[20:6];
                F_JALR: begin
                    rsvd_bad = |{rt, sa};
                    cls_off  = !class_mask_i[CLS_LINK];
                end
                default:                          known = 1'b0;
            endcase
            OP_REGIMM: case (rt)
                RT_BLTZ, RT_BGEZ:                 ;
                RT_BLTZAL, RT_BGEZAL:             cls_off = !class_mask_i[CLS_LINK];
                default:                          known = 1'b0;
            endcase
            OP_BLEZ, OP_BGTZ:                     rsvd_bad = |rt;
            OP_JAL:                               cls_off = !class_mask_i[CLS_LINK];
            OP_LWL, OP_LWR:                       cls_off = !class_mask_i[CLS_LWLR];
            OP_J, OP_BEQ, OP_BNE, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
            OP_LUI, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: ;
            default:                              known = 1'b0;
        endcase

        if (!known)        cause_o = CAUSE_UNKNOWN;
        else if (rsvd_bad) cause_o = CAUSE_RSVD;
        else if (cls_off)  cause_o = CAUSE_DISABLED;
        else               cause_o = CAUSE_OK;

        legal_o = (cause_o == CAUSE_OK);
        nop_o   = (instr_i == 32'h0);
    end

endmodule

// File: rtl/pipe_instr_checker.sv
// pipe_instr_checker: pipelined MIPS-I legality checker between fetch and decode.
//   in_valid/in_instr/in_pc : instruction entering the checker
//   stall / flush           : freeze all stages / drop all in-flight stages (flush wins)
//   class_mask              : enables for MULDIV, HI/LO moves, LWL/LWR, link branches
//   out_valid/legal/nop/cause : result stage, PIPE_STAGES cycles after acceptance
//   exc_pending/exc_pc/exc_instr/exc_ack : sticky first-illegal record
//   illegal_count           : saturating count of illegal results
// Optional macro PIPE_INSTR_CHK_STATS_EN adds legal_count and nop_count outputs.
module pipe_instr_checker
    import pipe_instr_pkg::*;
#(
    parameter int PIPE_STAGES = 1,
    parameter int CNT_WIDTH   = 16,
    parameter int PC_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [31:0]          in_instr,
    input  logic [PC_WIDTH-1:0]  in_pc,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [3:0]           class_mask,
    output logic                 out_valid,
    output logic                 out_legal,
    output logic                 out_nop,
    output logic [1:0]           out_cause,
    output logic                 exc_pending,
    output logic [PC_WIDTH-1:0]  exc_pc,
    output logic [31:0]          exc_instr,
    input  logic                 exc_ack,
    output logic [CNT_WIDTH-1:0] illegal_count
`ifdef PIPE_INSTR_CHK_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] legal_count,
    output logic [CNT_WIDTH-1:0] nop_count
`endif
);
    logic   cls_legal, cls_nop;
    cause_e cls_cause;
    stage_t in_rec, res;
    stage_t [PIPE_STAGES-1:0] stage_q, stage_d;

    pipe_instr_classify u_classify (
        .instr_i      (in_instr),
        .class_mask_i (class_mask),
        .legal_o      (cls_legal),
        .nop_o        (cls_nop),
        .cause_o      (cls_cause)
    );

    always_comb begin
        in_rec       = '0;
        in_rec.valid = in_valid;
        in_rec.legal = cls_legal;
        in_rec.nop   = cls_nop;
        in_rec.cause = cls_cause;
        in_rec.pc    = PC_MAX_WIDTH'(in_pc);
        in_rec.instr = in_instr;
    end

    assign stage_d[0] = in_rec;
    for (genvar g = 1; g < PIPE_STAGES; g++) begin : g_chain
        assign stage_d[g] = stage_q[g-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else if (flush) begin
            for (int i = 0; i < PIPE_STAGES; i++) stage_q[i].valid <= 1'b0;
        end else if (!stall) begin
            stage_q <= stage_d;
        end
    end

    assign res       = stage_q[PIPE_STAGES-1];
    assign out_valid = res.valid;
    assign out_legal = res.valid & res.legal;
    assign out_nop   = res.valid & res.nop;
    assign out_cause = res.valid ? res.cause : CAUSE_OK;

    if (PC_WIDTH < PC_MAX_WIDTH) begin : g_pc_hi
        logic unused_pc_hi;
        assign unused_pc_hi = |res.pc[PC_MAX_WIDTH-1:PC_WIDTH];
    end

    // A result is only consumed on a non-stalled cycle, so a held result
    // produces exactly one event when it finally leaves.
    logic ev_ill;
    assign ev_ill = res.valid & ~res.legal & ~stall;

    logic                 exc_pending_q, exc_pending_d;
    logic [PC_WIDTH-1:0]  exc_pc_q, exc_pc_d;
    logic [31:0]          exc_instr_q, exc_instr_d;
    logic [CNT_WIDTH-1:0] ill_cnt_q, ill_cnt_d;

    always_comb begin
        exc_pending_d = exc_pending_q;
        exc_pc_d      = exc_pc_q;
        exc_instr_d   = exc_instr_q;
        // An ack in the same cycle as a new event frees the slot for that event.
        if (ev_ill && (!exc_pending_q || exc_ack)) begin
            exc_pending_d = 1'b1;
            exc_pc_d      = res.pc[PC_WIDTH-1:0];
            exc_instr_d   = res.instr;
        end else if (exc_ack) begin
            exc_pending_d = 1'b0;
        end
        ill_cnt_d = ill_cnt_q + {{(CNT_WIDTH-1){1'b0}}, (ev_ill && !(&ill_cnt_q))};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exc_pending_q <= 1'b0;
            exc_pc_q      <= '0;
            exc_instr_q   <= '0;
            ill_cnt_q     <= '0;
        end else begin
            exc_pending_q <= exc_pending_d;
            exc_pc_q      <= exc_pc_d;
            exc_instr_q   <= exc_instr_d;
            ill_cnt_q     <= ill_cnt_d;
        end
    end

    assign exc_pending   = exc_pending_q;
    assign exc_pc        = exc_pc_q;
    assign exc_instr     = exc_instr_q;
    assign illegal_count = ill_cnt_q;

`ifdef PIPE_INSTR_CHK_STATS_EN
    logic                 ev_legal, ev_nop;
    logic [CNT_WIDTH-1:0] legal_cnt_q, legal_cnt_d, nop_cnt_q, nop_cnt_d;

    assign ev_legal    = res.valid & res.legal & ~stall;
    assign ev_nop      = res.valid & res.nop & ~stall;
    assign legal_cnt_d = legal_cnt_q + {{(CNT_WIDTH-1){1'b0}}, (ev_legal && !(&legal_cnt_q))};
    assign nop_cnt_d   = nop_cnt_q + {{(CNT_WIDTH-1){1'b0}}, (ev_nop && !(&nop_cnt_q))};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            legal_cnt_q <= '0;
            nop_cnt_q   <= '0;
        end else begin
            legal_cnt_q <= legal_cnt_d;
            nop_cnt_q   <= nop_cnt_d;
        end
    end

    assign legal_count = legal_cnt_q;
    assign nop_count   = nop_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_instr_checker.sv
// Scoreboard bench for pipe_instr_checker: driver pushes expected results from a
// table-style reference model; a negedge monitor pops and compares.
module tb_pipe_instr_checker;
    localparam int PS = 2, CW = 8, PW = 32;
    localparam int MAXC = (1 << CW) - 1;
    localparam logic [31:0] M_RS = 32'h03E0_0000, M_RT = 32'h001F_0000,
                            M_RD = 32'h0000_F800, M_SA = 32'h0000_07C0;

    logic          clk = 1'b0, reset;
    logic          in_valid, stall, flush, exc_ack;
    logic [31:0]   in_instr;
    logic [PW-1:0] in_pc;
    logic [3:0]    class_mask, cur_mask;
    logic          out_valid, out_legal, out_nop, exc_pending;
    logic [1:0]    out_cause;
    logic [PW-1:0] exc_pc;
    logic [31:0]   exc_instr;
    logic [CW-1:0] illegal_count;
`ifdef PIPE_INSTR_CHK_STATS_EN
    logic [CW-1:0] legal_count, nop_count;
`endif

    pipe_instr_checker #(.PIPE_STAGES(PS), .CNT_WIDTH(CW), .PC_WIDTH(PW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .stall(stall), .flush(flush), .class_mask(class_mask),
        .out_valid(out_valid), .out_legal(out_legal), .out_nop(out_nop), .out_cause(out_cause),
        .exc_pending(exc_pending), .exc_pc(exc_pc), .exc_instr(exc_instr), .exc_ack(exc_ack),
        .illegal_count(illegal_count)
`ifdef PIPE_INSTR_CHK_STATS_EN
        , .legal_count(legal_count), .nop_count(nop_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          legal;
        logic          nop;
        logic [1:0]    cause;
        logic [31:0]   instr;
        logic [PW-1:0] pc;
        int            age;
    } exp_t;

    exp_t q[$];
    int checks = 0, failures = 0;
    logic          m_pend;
    logic [PW-1:0] m_pc;
    logic [31:0]   m_instr;
    int            m_ill, m_leg, m_nop;
    logic          vis, ev;

    logic [5:0] FN  [24] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                             6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
                             6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h20};
    logic [5:0] OPS [25] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h09, 6'h0A,
                             6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h22,
                             6'h23, 6'h24, 6'h25, 6'h26, 6'h28, 6'h29, 6'h2B, 6'h08, 6'h3F};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Table view of the ISA subset: which words are known, which bits must be
    // zero, and which class_mask bit (if any) gates the instruction.
    function automatic void decode(input logic [31:0] w, output bit known,
                                   output logic [31:0] rsv, output int cls);
        known = 1; rsv = 32'h0; cls = -1;
        case (w[31:26])
            6'h00: case (w[5:0])
                6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                6'h04, 6'h06, 6'h07:             rsv = M_SA;
                6'h00, 6'h02, 6'h03:             rsv = M_RS;
                6'h18, 6'h19, 6'h1A, 6'h1B:      begin rsv = M_RD | M_SA; cls = 0; end
                6'h10, 6'h12:                    begin rsv = M_RS | M_RT | M_SA; cls = 1; end
                6'h11, 6'h13:                    begin rsv = M_RT | M_RD | M_SA; cls = 1; end
                6'h08:                           rsv = 32'h001F_FFC0;
                6'h09:                           begin rsv = M_RT | M_SA; cls = 3; end
                default:                         known = 0;
            endcase
            6'h01: case (w[20:16])
                5'h00, 5'h01:                    ;
                5'h10, 5'h11:                    cls = 3;
                default:                         known = 0;
            endcase
            6'h06, 6'h07:                        rsv = M_RT;
            6'h03:                               cls = 3;
            6'h22, 6'h26:                        cls = 2;
            6'h02, 6'h04, 6'h05, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: ;
            default:                             known = 0;
        endcase
    endfunction

    function automatic exp_t ref_model(input logic [31:0] w, input logic [3:0] m, input logic [PW-1:0] pc);
        exp_t e; bit known; logic [31:0] rsv; int cls;
        decode(w, known, rsv, cls);
        if (!known)                      e.cause = 2'd1;
        else if ((w & rsv) != 0)         e.cause = 2'd2;
        else if (cls >= 0 && !m[cls])    e.cause = 2'd3;
        else                             e.cause = 2'd0;
        e.legal = (e.cause == 2'd0);
        e.nop   = (w == 32'h0);
        e.instr = w; e.pc = pc; e.age = 0;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w; bit known; logic [31:0] rsv; int cls; int k;
        w = $urandom; k = $urandom_range(0, 9);
        if (k == 0) return 32'h0;
        if (k >= 3 && k <= 6) begin w[31:26] = 6'h00; w[5:0] = FN[$urandom_range(0, 23)]; end
        if (k == 7) begin
            w[31:26] = 6'h01;
            if ($urandom_range(0, 3) != 0) w[20:16] = {w[20], 3'b000, w[16]};
        end
        if (k >= 8) w[31:26] = OPS[$urandom_range(0, 24)];
        decode(w, known, rsv, cls);
        if ($urandom_range(0, 3) != 0) w = w & ~rsv;
        return w;
    endfunction

    task automatic cyc(input logic v, input logic [31:0] w, input logic [PW-1:0] pc,
                       input logic st, input logic fl, input logic ack);
        @(posedge clk); #2;
        in_valid = v; in_instr = w; in_pc = pc; stall = st; flush = fl; exc_ack = ack;
        class_mask = cur_mask;
        if (v && !st && !fl) q.push_back(ref_model(w, cur_mask, pc));
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compares the result stage against the scoreboard head and the
    // exception/counter state against the model, then advances the model.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_exc_pending", exc_pending, 0);
            chk("rst_illegal_count", illegal_count, 0);
            q.delete();
            m_pend = 0; m_pc = '0; m_instr = '0; m_ill = 0; m_leg = 0; m_nop = 0;
        end else begin
            vis = (q.size() > 0) && (q[0].age == PS);
            chk("out_valid", out_valid, vis);
            if (vis) begin
                chk("out_legal", out_legal, q[0].legal);
                chk("out_nop", out_nop, q[0].nop);
                chk("out_cause", out_cause, q[0].cause);
            end else begin
                chk("idle_out_fields", {out_legal, out_nop, out_cause}, 0);
            end
            chk("exc_pending", exc_pending, m_pend);
            chk("exc_pc", exc_pc, m_pc);
            chk("exc_instr", exc_instr, m_instr);
            chk("illegal_count", illegal_count, m_ill);
`ifdef PIPE_INSTR_CHK_STATS_EN
            chk("legal_count", legal_count, m_leg);
            chk("nop_count", nop_count, m_nop);
`endif
            ev = vis && !stall;
            if (ev && !q[0].legal) begin
                if (!m_pend || exc_ack) begin m_pend = 1; m_pc = q[0].pc; m_instr = q[0].instr; end
                if (m_ill < MAXC) m_ill++;
            end else if (exc_ack) begin
                m_pend = 0;
            end
            if (ev && q[0].legal && m_leg < MAXC) m_leg++;
            if (ev && q[0].nop && m_nop < MAXC) m_nop++;
            if (flush) q.delete();
            else if (!stall) begin
                if (vis) void'(q.pop_front());
                foreach (q[i]) q[i].age++;
            end
        end
    end

    initial begin
        reset = 1; in_valid = 0; in_instr = 0; in_pc = 0; stall = 0; flush = 0;
        exc_ack = 0; cur_mask = 4'hF; class_mask = 4'hF;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_exc_pc", exc_pc, 0);
        chk("reset_exc_instr", exc_instr, 0);
        repeat (3) @(posedge clk);
        #2 reset = 0;

        // legal ADDU, then ADDU with sa=1
        cyc(1, 32'h0085_1021, 32'h0, 0, 0, 0);
        idle(3);
        cyc(1, 32'h0085_1061, 32'h100, 0, 0, 0);
        idle(3);
        chk("first_exc_pending", exc_pending, 1);
        chk("first_exc_pc", exc_pc, 32'h100);
        chk("first_exc_instr", exc_instr, 32'h0085_1061);
        chk("first_illegal_count", illegal_count, 1);

        // MULT with its class disabled; record keeps the first capture
        cur_mask = 4'hE;
        cyc(1, 32'h0085_0018, 32'h104, 0, 0, 0);
        idle(3);
        cur_mask = 4'hF;
        chk("second_exc_pc_kept", exc_pc, 32'h100);
        chk("second_illegal_count", illegal_count, 2);
        cyc(0, 32'h0, '0, 0, 0, 1);
        idle(1);
        chk("ack_clears_pending", exc_pending, 0);

        // flush one cycle before the illegal word reaches the result stage
        cyc(1, 32'hFC00_0000, 32'h140, 0, 0, 0);
        cyc(0, 32'h0, '0, 0, 1, 0);
        idle(3);
        chk("flush_count_unchanged", illegal_count, 2);

        // illegal held three cycles under stall counts once
        cyc(1, 32'hFC00_0000, 32'h180, 0, 0, 0);
        idle(1);
        repeat (3) cyc(0, 32'h0, '0, 1, 0, 0);
        idle(2);
        chk("stall_count_once", illegal_count, 3);
        chk("stall_exc_pc", exc_pc, 32'h180);

        // ack coincides with a new illegal result
        cyc(1, 32'hFC00_0000, 32'h200, 0, 0, 0);
        idle(1);
        cyc(0, 32'h0, '0, 0, 0, 1);
        idle(1);
        chk("ack_event_pending", exc_pending, 1);
        chk("ack_event_pc", exc_pc, 32'h200);
        chk("ack_event_count", illegal_count, 4);

        // all-zero word
        cyc(1, 32'h0, 32'h300, 0, 0, 0);
        idle(3);

        // asynchronous reset mid-stream
        cyc(1, 32'hFC00_0000, 32'h400, 0, 0, 0);
        cyc(1, 32'h0085_1021, 32'h404, 0, 0, 0);
        @(posedge clk); #3;
        reset = 1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_fields", {out_legal, out_nop, out_cause}, 0);
        chk("async_rst_pending", exc_pending, 0);
        chk("async_rst_pc", exc_pc, 0);
        chk("async_rst_count", illegal_count, 0);
        in_valid = 0; stall = 0; flush = 0; exc_ack = 0;
        repeat (2) @(posedge clk);
        #2 reset = 0;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) cur_mask = 4'($urandom);
            cyc($urandom_range(0, 3) != 0, rand_instr(), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0);
        end
        idle(PS + 3);
        chk("scoreboard_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_instr_checker.md
Name: pipe_instr_checker

Overview:
- Pipelined legality checker for MIPS-I instruction words, placed between fetch and decode in the pipelined core.
- Classifies each incoming instruction as legal, illegal or disabled by the mode mask.
- Registers the result through a configurable number of stages that honour stall and flush.
- Captures the first illegal instruction in a sticky exception record until software acknowledges it, and counts illegal instructions.

Parameters:
- PIPE_STAGES, 1, result latency in cycles; legal values 1..3.
- CNT_WIDTH, 16, width of the illegal-instruction counter; the counter saturates.
- PC_WIDTH, 32, width of the program counter carried alongside each instruction.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_instr/in_pc are meaningful this cycle.
- in_instr  input  32  instruction word.
- in_pc  input  PC_WIDTH  address of in_instr.
- stall  input  1  freeze all stages; no input is accepted.
- flush  input  1  invalidate every in-flight stage.
- class_mask  input  4  enable bits: [0] MULT/DIV/MULTU/DIVU, [1] MFHI/MFLO/MTHI/MTLO, [2] LWL/LWR, [3] link branches (BLTZAL/BGEZAL/JAL/JALR).
- out_valid  output  1  result stage holds a live instruction.
- out_legal  output  1  instruction is legal and enabled.
- out_nop  output  1  instruction word is all-zero.
- out_cause  output  2  0 ok, 1 unknown encoding, 2 nonzero reserved field, 3 class disabled.
- exc_pending  output  1  sticky exception record is full.
- exc_pc  output  PC_WIDTH  PC of the captured illegal instruction.
- exc_instr  output  32  word of the captured illegal instruction.
- exc_ack  input  1  clears the record.
- illegal_count  output  CNT_WIDTH  saturating count of illegal results.

Behaviour:
- Classification is combinational on in_instr, then registered. Legal set:
  - SPECIAL (opcode 0):
    - ADDU/AND/NOR/OR/SLT/SLTU/SUBU/XOR/SLLV/SRAV/SRLV require sa==0.
    - SLL/SRL/SRA require rs==0.
    - MULT/MULTU/DIV/DIVU require rd==0 and sa==0.
    - MFHI/MFLO require rs==0, rt==0 and sa==0.
    - MTHI/MTLO require rt, rd and sa all zero.
    - JR requires [20:6]==0.
    - JALR requires rt==0 and sa==0.
  - REGIMM (opcode 1) with rt in {00000, 00001, 10000, 10001}.
  - BLEZ/BGTZ with rt==0.
  - Opcodes J, JAL, BEQ, BNE, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI, LB, LH, LWL, LW, LBU, LHU, LWR, SB, SH, SW.
- Cause priority: unknown opcode/funct → 1; known but a reserved field is nonzero → 2; legal but its class_mask bit is 0 → 3; otherwise 0.
- All-zero word: out_legal=1, out_nop=1, cause 0.
- Pipeline:
  - PIPE_STAGES registers, each holding valid, legal, nop, cause, pc and instr.
  - Without stall, the result of an input accepted at cycle t appears at cycle t+PIPE_STAGES.
  - stall=1: every stage holds and in_valid is ignored.
  - flush=1: every stage valid bit clears next cycle and the input that cycle is discarded. flush has priority over stall.
  - out_legal, out_nop and out_cause are forced to 0 when out_valid=0.
- Exception record: an event is out_valid & ~out_legal at the result stage while stall=0.
  - If exc_pending=0, the event loads exc_pc/exc_instr and sets exc_pending.
  - Later events do not overwrite the record while it is pending.
  - exc_ack clears exc_pending. If exc_ack and an event occur in the same cycle, the new event is captured and exc_pending stays 1.
- illegal_count:
  - Increments once per event.
  - A held result under stall counts once, not once per cycle.
  - Saturates at 2^CNT_WIDTH-1.
  - Is not cleared by exc_ack.
- Reset, asynchronous: all stage valid bits 0, out_* 0, exc_pending 0, exc_pc 0, exc_instr 0, illegal_count 0. Reset mid-stream drops every in-flight instruction.

Optional Feature:
- Macro PIPE_INSTR_CHK_STATS_EN.
- Defined: adds output legal_count [CNT_WIDTH-1:0], a saturating count of results with out_valid & out_legal (same stall rule), and output nop_count [CNT_WIDTH-1:0] for out_nop. Both are cleared only by reset.
- Undefined: neither port nor its registers exist; all other behaviour is identical.

Decomposition:
- Package pipe_instr_pkg holds:
  - opcode/funct/REGIMM-rt localparams;
  - cause enum (CAUSE_OK, CAUSE_UNKNOWN, CAUSE_RSVD, CAUSE_DISABLED);
  - class_mask bit indices;
  - a stage-record struct (valid, legal, nop, cause, pc, instr).
- Sub-module pipe_instr_classify is purely combinational: in_instr and class_mask in; legal, nop and cause out. The top level holds the stage registers, the exception record and the counters.

Test Plan:
- PIPE_STAGES=2, class_mask=4'hF, in_instr 0x00851021 (ADDU) → two cycles later out_valid=1, out_legal=1, out_cause=0.
- in_instr 0x00851061 (ADDU with sa=1) at pc 0x100 → out_cause=2, exc_pending=1, exc_pc=0x100, exc_instr=0x00851061, illegal_count=1.
- class_mask[0]=0, in_instr 0x00850018 (MULT) → out_legal=0, cause 3; a second illegal at pc 0x104 leaves exc_pc=0x100 and sets illegal_count=2.
- Illegal word 0xFC000000 in flight plus flush one cycle before it reaches the result stage → out_valid never asserts and illegal_count is unchanged.
- Illegal result held 3 cycles by stall → illegal_count +1 only; exc_ack pulsed with a new illegal result the same cycle → exc_pending stays 1 with the new pc.
- in_instr 0x00000000 → out_legal=1, out_nop=1. Assert reset asynchronously mid-stream → all outputs 0 before the next clock edge.
